nes_oam_dma_arbiter: RTL and testbench

Sprite (OAM) DMA controller and CPU-bus arbiter for the NES core. A CPU write to $4014 starts a 256-byte copy from CPU page $XX00-$XXFF to the PPU OAM data port ($2004). The block halts the 6502 through RDY and takes ownership of the shared CPU address/data bus for the duration. It sits between the CPU core and the CPU-side memory map inside NES_toplevel.

---
 rtl/nes_bus_pkg.sv | 16 +
 rtl/nes_oam_dma_arbiter_if.sv | 25 ++
 rtl/nes_oam_dma_arbiter.sv | 104 ++++++++++
 tb/tb_nes_oam_dma_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU-bus types and register addresses for the NES core
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG   = 16'h4014;
  localparam logic [15:0] OAM_DATA_PORT = 16'h2004;
  localparam int unsigned OAM_XFER_LEN  = 256;

endpackage

// File: rtl/nes_oam_dma_arbiter_if.sv
// rtl/nes_oam_dma_arbiter_if.sv - CPU-side and memory-map-side bus signals around the OAM DMA arbiter
interface nes_oam_dma_arbiter_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic        dma_active;

  // CPU core / memory-map side
  modport master (
    output cpu_ce, cpu_addr, cpu_dout, cpu_we, bus_din,
    input  cpu_rdy, bus_addr, bus_dout, bus_we, dma_active
  );

  // arbiter side
  modport slave (
    input  cpu_ce, cpu_addr, cpu_dout, cpu_we, bus_din,
    output cpu_rdy, bus_addr, bus_dout, bus_we, dma_active
  );
endinterface

// File: rtl/nes_oam_dma_arbiter.sv
// rtl/nes_oam_dma_arbiter.sv - sprite DMA ($4014) controller that halts the 6502 and owns the CPU bus
module nes_oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_PORT,
  parameter int unsigned XFER_LEN      = OAM_XFER_LEN
) (
  input logic                 Clk,
  input logic                 reset,
  nes_oam_dma_arbiter_if.slave bus
);

  localparam logic [7:0] LAST_COUNT = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q, page_d;
  logic [7:0] count_q, count_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;
  logic       active_q, active_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    count_d  = count_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    active_d = active_q;
    if (bus.cpu_ce) begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR)) begin
            page_d   = bus.cpu_dout;
            count_d  = 8'h00;
            state_d  = HALT;
            rdy_d    = 1'b0;
            active_d = 1'b1;
          end
        end
        // first READ must land on a get (even) cycle
        HALT:    state_d = parity_q ? READ : ALIGN;
        ALIGN:   state_d = READ;
        READ: begin
          data_d  = bus.bus_din;
          state_d = WRITE;
        end
        WRITE: begin
          if (count_q == LAST_COUNT) begin
            state_d  = IDLE;
            rdy_d    = 1'b1;
            active_d = 1'b0;
          end else begin
            count_d = count_q + 8'd1;
            state_d = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      count_q  <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
    end else if (bus.cpu_ce) begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      count_q  <= count_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
    end
  end

  // HALT/ALIGN present a harmless read of the source page while the CPU is parked
  always_comb begin
    bus.bus_addr = bus.cpu_addr;
    bus.bus_dout = bus.cpu_dout;
    bus.bus_we   = bus.cpu_we;
    if (active_q) begin
      bus.bus_dout = data_q;
      if (state_q == WRITE) begin
        bus.bus_addr = OAM_DATA_ADDR;
        bus.bus_we   = 1'b1;
      end else begin
        bus.bus_addr = {page_q, count_q};
        bus.bus_we   = 1'b0;
      end
    end
  end

  assign bus.cpu_rdy    = rdy_q;
  assign bus.dma_active = active_q;

endmodule

// File: tb/tb_nes_oam_dma_arbiter.sv
// tb/tb_nes_oam_dma_arbiter.sv - randomized bench for the OAM DMA arbiter against a transfer-level model
module tb_nes_oam_dma_arbiter;
  import nes_bus_pkg::*;

  logic       Clk = 1'b0;
  logic       reset;
  int         checks = 0;
  int         failures = 0;
  int         ce_count = 0;
  int         halt_cnt = 0;
  int         zero_hits = 0;
  logic [7:0] seed = 8'h5A;
  logic [7:0] wq[$];

  nes_oam_dma_arbiter_if bus_if();

  nes_oam_dma_arbiter #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .XFER_LEN     (256)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 Clk = ~Clk;

  // memory map: every byte is a known function of its address
  always_comb bus_if.bus_din = bus_if.bus_addr[7:0] ^ bus_if.bus_addr[15:8] ^ seed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ce_cycle(input logic [15:0] a, input logic [7:0] d, input logic we);
    int          idle;
    logic [15:0] held_addr;
    logic        held_we;
    idle      = $urandom_range(0, 2);
    held_addr = bus_if.bus_addr;
    held_we   = bus_if.bus_we;
    repeat (idle) begin
      @(posedge Clk);
      #1;
    end
    if (idle > 0) begin
      check("hold_addr", 32'(bus_if.bus_addr), 32'(held_addr));
      check("hold_we", 32'(bus_if.bus_we), 32'(held_we));
    end
    bus_if.cpu_addr = a;
    bus_if.cpu_dout = d;
    bus_if.cpu_we   = we;
    bus_if.cpu_ce   = 1'b1;
    @(negedge Clk);
    if (bus_if.dma_active && bus_if.bus_we && bus_if.bus_addr == OAM_DATA_PORT)
      wq.push_back(bus_if.bus_dout);
    if (bus_if.dma_active && bus_if.bus_addr == 16'h0000) zero_hits++;
    if (!bus_if.cpu_rdy) halt_cnt++;
    @(posedge Clk);
    #1;
    bus_if.cpu_ce = 1'b0;
    ce_count++;
  endtask

  task automatic run_dma(input logic [7:0] page, input string tag);
    int c_par;
    int guard;
    int errs;
    int r;
    c_par     = ce_count % 2;
    halt_cnt  = 0;
    zero_hits = 0;
    wq.delete();
    ce_cycle(OAM_DMA_REG, page, 1'b1);
    check({tag, "_rdy_low"}, 32'(bus_if.cpu_rdy), 32'd0);
    check({tag, "_active"}, 32'(bus_if.dma_active), 32'd1);
    guard = 0;
    while (bus_if.cpu_rdy === 1'b0 && guard < 600) begin
      r = $urandom_range(0, 3);
      ce_cycle((r == 0) ? OAM_DMA_REG : 16'($urandom), 8'($urandom), 1'($urandom));
      guard++;
    end
    // halt = trigger-to-release cycles: 1 + 2*256, plus one when the CPU-visible parity needs alignment
    check({tag, "_halt_len"}, 32'(halt_cnt), 32'(513 + c_par));
    check({tag, "_nbytes"}, 32'(wq.size()), 32'd256);
    errs = 0;
    foreach (wq[i]) if (wq[i] !== (8'(i) ^ page ^ seed)) errs++;
    check({tag, "_data_errs"}, 32'(errs), 32'd0);
    check({tag, "_done_inactive"}, 32'(bus_if.dma_active), 32'd0);
    check({tag, "_no_0000"}, 32'(zero_hits), 32'd0);
  endtask

  initial begin
    int guard;
    reset           = 1'b1;
    bus_if.cpu_ce   = 1'b0;
    bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_dout = 8'h00;
    bus_if.cpu_we   = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rdy", 32'(bus_if.cpu_rdy), 32'd1);
    check("rst_active", 32'(bus_if.dma_active), 32'd0);
    check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    reset    = 1'b0;
    ce_count = 0;

    bus_if.cpu_addr = 16'h1234;
    bus_if.cpu_dout = 8'hAB;
    bus_if.cpu_we   = 1'b1;
    #1;
    check("pt_addr", 32'(bus_if.bus_addr), 32'h1234);
    check("pt_dout", 32'(bus_if.bus_dout), 32'hAB);
    check("pt_we", 32'(bus_if.bus_we), 32'd1);
    check("pt_rdy", 32'(bus_if.cpu_rdy), 32'd1);
    repeat (4) ce_cycle(16'($urandom_range(0, 16'h3FFF)), 8'($urandom), 1'($urandom));
    check("pt_still_idle", 32'(bus_if.dma_active), 32'd0);

    seed = 8'h5A;
    if (ce_count % 2 == 0) ce_cycle(16'h0000, 8'h00, 1'b0);
    run_dma(8'h02, "even");

    seed = 8'($urandom);
    if (ce_count % 2 == 1) ce_cycle(16'h0000, 8'h00, 1'b0);
    run_dma(8'h02, "odd");

    seed = 8'($urandom);
    run_dma(8'hFF, "wrap");

    wq.delete();
    ce_cycle(OAM_DMA_REG, 8'h07, 1'b1);
    guard = 0;
    while (wq.size() < 100 && guard < 400) begin
      ce_cycle(16'($urandom), 8'($urandom), 1'b0);
      guard++;
    end
    check("mid_reached_100", 32'(wq.size()), 32'd100);
    bus_if.cpu_addr = 16'h0ABC;
    bus_if.cpu_we   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(bus_if.cpu_rdy), 32'd1);
    check("mid_rst_active", 32'(bus_if.dma_active), 32'd0);
    check("mid_rst_passthru", 32'(bus_if.bus_addr), 32'h0ABC);
    @(posedge Clk);
    #1;
    reset    = 1'b0;
    ce_count = 0;
    seed = 8'($urandom);
    run_dma(8'h05, "restart");

    run_dma(8'h03, "b2b");
    ce_cycle(16'h0000, 8'h00, 1'b0);
    check("final_rdy", 32'(bus_if.cpu_rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
